// File: rtl/ifu_fetch_unit.sv
// ---------------------------------------------------------------------------
// ifu_fetch_unit
//
// Instruction fetch unit sitting in front of the decode stage.
//
// The unit owns the architectural PC. It issues one doubleword-aligned read
// at a time to instruction memory and picks the 32-bit half addressed by
// pc[2]. It holds that word towards decode until decode accepts it, then
// loads the next PC that decode computed. A misaligned next PC stops fetching
// for good. Only a reset restarts it.
//
// Only one memory request is ever outstanding. The state sequence is
// REQ -> WAIT -> HOLD -> REQ (or HALT).
//
// Optional build macro:
//   IFU_PERF_CNT_EN - adds two free-running 64-bit performance counters.
//
// Ports:
//   clk              system clock, rising edge
//   rst              asynchronous, active-high reset
//   imem_req_valid   fetch request valid (forced low while rst is high)
//   imem_req_ready   memory accepts the request
//   imem_req_addr    request address, {pc[63:3], 3'b000}
//   imem_resp_valid  single-cycle response strobe
//   imem_resp_data   doubleword read data
//   imem_resp_err    access fault, qualified by imem_resp_valid
//   out_valid        instr_o / pc_o / fetch_err_o valid to decode
//   out_ready        decode accepts the instruction
//   instr_o          fetched instruction (nop on a faulted fetch)
//   pc_o             PC of instr_o (always the current PC)
//   dnpc_i           next PC from decode, sampled on out_valid && out_ready
//   fetch_err_o      instr_o came from a faulted fetch
//   halt_o           misaligned next PC seen; fetching stopped
//   perf_fetch_cnt   (IFU_PERF_CNT_EN) instructions handed to decode
//   perf_stall_cnt   (IFU_PERF_CNT_EN) cycles spent waiting on memory
// ---------------------------------------------------------------------------
module ifu_fetch_unit #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  // instruction memory request channel
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  // instruction memory response channel
  input  logic            imem_resp_valid,
  input  logic [63:0]     imem_resp_data,
  input  logic            imem_resp_err,
  // decode interface
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     instr_o,
  output logic [XLEN-1:0] pc_o,
  input  logic [XLEN-1:0] dnpc_i,
  output logic            fetch_err_o,
  output logic            halt_o
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [63:0]     perf_fetch_cnt,
  output logic [63:0]     perf_stall_cnt
`endif
);

  // Canonical RISC-V nop (addi x0, x0, 0), handed to decode on a faulted fetch.
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2,
    ST_HALT = 2'd3
  } state_t;

  state_t            state_reg;
  state_t            state_next;

  logic [XLEN-1:0]   pc_reg;
  logic [31:0]       instr_reg;
  logic [31:0]       instr_next;
  logic              err_reg;

  logic              resp_take;     // response accepted this cycle
  logic              accept_fire;   // decode took the held instruction
  logic              dnpc_aligned;  // dnpc_i is a legal 4-byte-aligned target

  // -------------------------------------------------------------------------
  // Split the read doubleword into its two 32-bit halves. pc[2] picks one.
  // -------------------------------------------------------------------------
  logic [31:0] resp_word [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_resp_word
    assign resp_word[gi] = imem_resp_data[32*gi +: 32];
  end

  // Responses count only in WAIT. A pulse in any other state is either
  // stale (left over from before a reset) or spurious. It must not disturb
  // the held instruction.
  assign resp_take    = (state_reg == ST_WAIT) && imem_resp_valid;
  assign accept_fire  = (state_reg == ST_HOLD) && out_ready;
  // The decoder already clears bit 0. Both low bits are still checked so a
  // broken decoder cannot slip a halfword target through.
  assign dnpc_aligned = (dnpc_i[1:0] == 2'b00);

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_REQ;
    end else begin
      state_reg <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_REQ: begin
        // A response arriving together with the request handshake is ignored.
        // The request that was just accepted has not been answered yet.
        if (imem_req_ready) begin
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem_resp_valid) begin
          state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          state_next = dnpc_aligned ? ST_REQ : ST_HALT;
        end
      end
      ST_HALT: begin
        state_next = ST_HALT;
      end
      default: begin
        state_next = ST_REQ;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs
  // -------------------------------------------------------------------------
  always_comb begin
    // The reset already puts the state in REQ. The request is also gated by
    // rst so that nothing is offered to memory while reset is asserted.
    imem_req_valid = (state_reg == ST_REQ) && !rst;
    out_valid      = (state_reg == ST_HOLD);
    halt_o         = (state_reg == ST_HALT);
  end

  // -------------------------------------------------------------------------
  // Architectural PC. It advances only when decode accepts an instruction
  // and the new target is aligned. On a halt it keeps the PC of the last
  // instruction.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg <= RESET_PC;
    end else if (accept_fire && dnpc_aligned) begin
      pc_reg <= dnpc_i;
    end
  end

  // -------------------------------------------------------------------------
  // Held instruction and fault flag. They load once per fetch, when the
  // response is taken, and stay stable through HOLD until decode accepts.
  // -------------------------------------------------------------------------
  always_comb begin
    instr_next = resp_word[pc_reg[2]];
    if (imem_resp_err) begin
      instr_next = INSTR_NOP;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_reg <= 32'h0;
      err_reg   <= 1'b0;
    end else if (resp_take) begin
      instr_reg <= instr_next;
      err_reg   <= imem_resp_err;
    end
  end

  assign imem_req_addr = {pc_reg[XLEN-1:3], 3'b000};
  assign pc_o          = pc_reg;
  assign instr_o       = instr_reg;
  assign fetch_err_o   = err_reg;

`ifdef IFU_PERF_CNT_EN
  // -------------------------------------------------------------------------
  // Performance counters. Both wrap naturally at 2^64.
  //   fetch: one count per instruction handed to decode
  //   stall: one count per cycle the unit is blocked on memory, either a
  //          request not yet accepted or a response not yet returned
  // -------------------------------------------------------------------------
  logic        stall_cycle;
  logic [63:0] perf_fetch_cnt_reg;
  logic [63:0] perf_stall_cnt_reg;

  assign stall_cycle = ((state_reg == ST_REQ)  && !imem_req_ready) ||
                       ((state_reg == ST_WAIT) && !imem_resp_valid);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_cnt_reg <= 64'd0;
      perf_stall_cnt_reg <= 64'd0;
    end else begin
      if (accept_fire) begin
        perf_fetch_cnt_reg <= perf_fetch_cnt_reg + 64'd1;
      end
      if (stall_cycle) begin
        perf_stall_cnt_reg <= perf_stall_cnt_reg + 64'd1;
      end
    end
  end

  assign perf_fetch_cnt = perf_fetch_cnt_reg;
  assign perf_stall_cnt = perf_stall_cnt_reg;
`endif

endmodule

// File: doc/ifu_fetch_unit.md
Name: ifu_fetch_unit

Overview:
Instruction fetch unit feeding the decode stage. It is the producer end of the decoder's instr/pc input and the consumer of the decoder's dnpc output. It owns the architectural PC and issues 64-bit-aligned requests to instruction memory over a valid/ready handshake. It selects the 32-bit word and presents it to decode with valid/ready. On acceptance it loads the decoder-computed next PC.

Parameters:
RESET_PC, 64'h0000_0000_8000_0000, PC value loaded on reset
XLEN, 64, PC/address width (only 64 supported)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request
imem_req_addr  output  64  request address, {pc[63:3],3'b000}
imem_resp_valid  input  1  response data valid (single-cycle pulse)
imem_resp_data  input  64  doubleword read data
imem_resp_err  input  1  access fault, qualified by imem_resp_valid
out_valid  output  1  instr_o/pc_o valid to decode
out_ready  input  1  decode accepts instruction
instr_o  output  32  fetched instruction
pc_o  output  64  PC of instr_o
dnpc_i  input  64  next PC from decode, sampled on out_valid&&out_ready
fetch_err_o  output  1  instr_o is a faulted fetch (valid with out_valid)
halt_o  output  1  misaligned next PC detected; fetch stopped

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on rst. While rst=1: state=REQ, pc=RESET_PC, instr_o=0, fetch_err_o=0, halt_o=0, out_valid=0, imem_req_valid=0 (gated by rst).
- States: REQ, WAIT, HOLD, HALT.
- REQ:
  - imem_req_valid=1 and imem_req_addr={pc[63:3],3'b000}.
  - On imem_req_ready, go to WAIT. Otherwise hold the request; the address stays stable.
- WAIT:
  - imem_req_valid=0.
  - On imem_resp_valid: instr_o = pc[2] ? data[63:32] : data[31:0], fetch_err_o=imem_resp_err, then go to HOLD.
  - On error, instr_o=32'h0000_0013 (nop).
- HOLD:
  - out_valid=1. instr_o, pc_o and fetch_err_o are stable until accepted.
  - On out_ready, sample dnpc_i.
  - If dnpc_i[1:0]==0: pc<=dnpc_i, go to REQ.
  - Otherwise go to HALT with halt_o=1.
- HALT: terminal until reset. out_valid=0, imem_req_valid=0.
- pc_o = pc at all times.
- Latency: request in cycle N accepted, response at N+k, out_valid at N+k+1. Best case is 3 cycles per instruction with zero-wait memory and out_ready tied high.
- imem_resp_valid outside WAIT is ignored. This covers stale responses after a reset mid-transaction.
- Reset asserted in any state aborts immediately. The first request after deassertion is to RESET_PC, on the first clk edge.
- Simultaneous req_ready and resp_valid in REQ: the response is ignored (a single outstanding request only).
- The decoder already forces dnpc bit 0 to 0, so only dnpc_i[1] can trigger HALT. The check still covers [1:0].

Optional Feature:
Macro IFU_PERF_CNT_EN.
- Defined: adds outputs perf_fetch_cnt[63:0] and perf_stall_cnt[63:0], both reset to 0.
  - perf_fetch_cnt increments on each out_valid&&out_ready.
  - perf_stall_cnt increments on each cycle in REQ with imem_req_ready=0, or in WAIT with imem_resp_valid=0.
  - Both counters wrap at 2^64.
- Undefined: these ports and registers are absent; all other behaviour is identical.

Test Plan:
- Reset → first request: release rst → imem_req_valid=1 and imem_req_addr=64'h8000_0000 in the first cycle. Return data 64'h0000_0093_0010_0073 → instr_o=32'h0010_0073, pc_o=64'h8000_0000.
- Upper-word select: dnpc_i=64'h8000_0004 → next request addr=64'h8000_0000, and instr_o=data[63:32]=32'h0000_0093.
- Backpressure: hold out_ready=0 for 5 cycles → out_valid and instr_o stay stable and no new request is issued. Raising out_ready with dnpc_i=64'h8000_0100 → imem_req_addr=64'h8000_0100 the next cycle.
- Access fault: respond with imem_resp_err=1 → fetch_err_o=1 with instr_o=32'h0000_0013. Accepting it with dnpc_i=64'h8000_0008 resumes fetching normally with fetch_err_o=0.
- Misaligned target: accept with dnpc_i=64'h8000_0102 → halt_o=1, out_valid=0 and imem_req_valid=0 forever, until rst pulse → restarts at 64'h8000_0000.
- Async reset mid-WAIT: assert rst between clock edges while in WAIT, then deliver imem_resp_valid after release → the response is ignored and the new request is to RESET_PC. With IFU_PERF_CNT_EN, both counters read 0 after reset.
